// File: rtl/l1_clfill_pkg.sv
// l1_clfill_pkg
// Shared types and helpers for the L1 cacheline fill responder:
//   - default sizing localparams (streams, lines per stream, data width, reads in flight)
//   - tag_t: {sid, clid} carried from L2 read issue to L2 data return
//   - rr_pick_t / rr_next: round-robin search starting after the last grantee
package l1_clfill_pkg;

  localparam int NSTREAMS   = 4;
  localparam int NCL        = 16;
  localparam int CL_WIDTH   = 512;
  localparam int NOUT       = 4;
  localparam int SID_WIDTH  = $clog2(NSTREAMS);
  localparam int CLID_WIDTH = $clog2(NCL);
  localparam int TAG_WIDTH  = SID_WIDTH + CLID_WIDTH;

  typedef struct packed {
    logic [SID_WIDTH-1:0]  sid;
    logic [CLID_WIDTH-1:0] clid;
  } tag_t;

  typedef struct packed {
    logic                 hit;
    logic [SID_WIDTH-1:0] sid;
  } rr_pick_t;

  // Walks candidates from the farthest (last+NSTREAMS, i.e. last itself)
  // down to the nearest (last+1); later matches overwrite earlier ones,
  // so the survivor is the first eligible stream after 'last'.
  function automatic rr_pick_t rr_next(input logic [SID_WIDTH-1:0] last,
                                       input logic [NSTREAMS-1:0]  elig);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = NSTREAMS; k >= 1; k--) begin
      idx = (int'(last) + k) % NSTREAMS;
      if (elig[idx[SID_WIDTH-1:0]]) begin
        pick.hit = 1'b1;
        pick.sid = idx[SID_WIDTH-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/l1_clfill_tagq.sv
// l1_clfill_tagq
// Synchronous FIFO holding the tags of L2 reads that have been accepted
// but whose data has not yet come back. Push and pop may happen in the
// same cycle. Occupancy is exported so the arbiter can bound reads in flight.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, push_data enqueue a tag
//   pop             dequeue the head (ignored when empty)
//   head_data       oldest tag
//   head_valid      FIFO not empty
//   count           number of stored tags
module l1_clfill_tagq
  import l1_clfill_pkg::*;
#(
  parameter int depth = NOUT,
  parameter int width = TAG_WIDTH,
  localparam int cnt_width = $clog2(depth + 1),
  localparam int ptr_width = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [width-1:0]     push_data,
  input  logic                 pop,
  output logic [width-1:0]     head_data,
  output logic                 head_valid,
  output logic [cnt_width-1:0] count
);

  logic [width-1:0]     mem_q [depth];
  logic [width-1:0]     mem_d [depth];
  logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0] count_q, count_d;
  logic                 do_push, do_pop;

  // Pointers wrap at depth, which need not be a power of two.
  function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
    return (int'(p) == depth - 1) ? '0 : p + ptr_width'(1);
  endfunction

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & head_valid;
    do_push  = push & ((count_q != cnt_width'(depth)) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + cnt_width'(do_push) - cnt_width'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/l1_clfill_rsp.sv
// l1_clfill_rsp
// Responder for the L1 cacheline request/response handshake. Grants one
// stream request per cycle (round-robin), issues a tagged L2 read for the
// stream's next fill line, and when L2 data returns (in issue order) writes
// it into the L1 line buffer and pulses that stream's response.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   i_set_v, i_set_clid              per-stream fill pointer load
//   i_clreq_v / i_clreq_r            per-stream line request / grant
//   o_rd_v/o_rd_r/o_rd_sid/o_rd_clid L2 read issue
//   i_rd_v/i_rd_r/i_rd_data          L2 read data return
//   o_wr_v/o_wr_sid/o_wr_clid/o_wr_data L1 line buffer write
//   o_clrsp_v / i_clrsp_r            per-stream line response
module l1_clfill_rsp
  import l1_clfill_pkg::*;
#(
  parameter int nstreams   = NSTREAMS,
  parameter int ncl        = NCL,
  parameter int cl_width   = CL_WIDTH,
  parameter int nout       = NOUT,
  parameter int sid_width  = $clog2(nstreams),
  parameter int clid_width = $clog2(ncl)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [nstreams-1:0]            i_set_v,
  input  logic [nstreams*clid_width-1:0] i_set_clid,
  input  logic [nstreams-1:0]            i_clreq_v,
  output logic [nstreams-1:0]            i_clreq_r,
  output logic                           o_rd_v,
  input  logic                           o_rd_r,
  output logic [sid_width-1:0]           o_rd_sid,
  output logic [clid_width-1:0]          o_rd_clid,
  input  logic                           i_rd_v,
  output logic                           i_rd_r,
  input  logic [cl_width-1:0]            i_rd_data,
  output logic                           o_wr_v,
  output logic [sid_width-1:0]           o_wr_sid,
  output logic [clid_width-1:0]          o_wr_clid,
  output logic [cl_width-1:0]            o_wr_data,
  output logic [nstreams-1:0]            o_clrsp_v,
  input  logic [nstreams-1:0]            i_clrsp_r
);

  localparam int cnt_width = $clog2(nout + 1);

  logic [clid_width-1:0] fptr_q [nstreams];
  logic [clid_width-1:0] fptr_d [nstreams];
  logic [sid_width-1:0]  last_q, last_d;
  logic                  iss_v_q, iss_v_d;
  logic [sid_width-1:0]  iss_sid_q, iss_sid_d;
  logic [clid_width-1:0] iss_clid_q, iss_clid_d;

  tag_t                  push_tag, head_tag;
  logic                  head_valid;
  logic [cnt_width-1:0]  tag_count;
  logic [cnt_width:0]    inflight;
  logic [nstreams-1:0]   elig;
  rr_pick_t              pick;
  logic                  can_grant, grant_v, issue_fire, rsp_fire;

  assign o_rd_v     = iss_v_q;
  assign o_rd_sid   = iss_sid_q;
  assign o_rd_clid  = iss_clid_q;
  assign issue_fire = iss_v_q & o_rd_r;
  assign push_tag   = '{sid: iss_sid_q, clid: iss_clid_q};

  l1_clfill_tagq #(
    .depth (nout),
    .width (TAG_WIDTH)
  ) u_tagq (
    .clk        (clk),
    .reset      (reset),
    .push       (issue_fire),
    .push_data  (push_tag),
    .pop        (rsp_fire),
    .head_data  (head_tag),
    .head_valid (head_valid),
    .count      (tag_count)
  );

  // Capacity uses registered occupancy only, so a pop this cycle frees a
  // slot for the next cycle. A grant may overlap the issue stage draining.
  // Gating with reset keeps the grant low while reset is held.
  always_comb begin
    inflight  = {1'b0, tag_count} + (cnt_width + 1)'(iss_v_q);
    elig      = i_clreq_v & ~i_set_v;
    pick      = rr_next(last_q, elig);
    can_grant = (inflight < (cnt_width + 1)'(nout)) & (~iss_v_q | o_rd_r);
    grant_v   = reset & can_grant & pick.hit;
    i_clreq_r = '0;
    if (grant_v) i_clreq_r[pick.sid] = 1'b1;
  end

  // Data return is steered purely by the head tag; the write and the
  // response pulse are combinational with the L2 data handshake.
  always_comb begin
    i_rd_r    = head_valid & i_clrsp_r[head_tag.sid];
    rsp_fire  = i_rd_v & i_rd_r;
    o_wr_v    = rsp_fire;
    o_wr_sid  = '0;
    o_wr_clid = '0;
    o_wr_data = '0;
    o_clrsp_v = '0;
    if (rsp_fire) begin
      o_wr_sid  = head_tag.sid;
      o_wr_clid = head_tag.clid;
      o_wr_data = i_rd_data;
      o_clrsp_v[head_tag.sid] = 1'b1;
    end
  end

  // Issue stage, fill pointers and round-robin history. A set never
  // collides with a grant on the same stream because set streams are
  // excluded from eligibility.
  always_comb begin
    fptr_d     = fptr_q;
    last_d     = last_q;
    iss_v_d    = iss_v_q;
    iss_sid_d  = iss_sid_q;
    iss_clid_d = iss_clid_q;
    if (issue_fire) iss_v_d = 1'b0;
    if (grant_v) begin
      iss_v_d             = 1'b1;
      iss_sid_d           = pick.sid;
      iss_clid_d          = fptr_q[pick.sid];
      fptr_d[pick.sid]    = fptr_q[pick.sid] + clid_width'(1);
      last_d              = pick.sid;
    end
    for (int s = 0; s < nstreams; s++) begin
      if (i_set_v[s]) fptr_d[s] = i_set_clid[s*clid_width +: clid_width];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < nstreams; s++) fptr_q[s] <= '0;
      last_q     <= sid_width'(nstreams - 1);
      iss_v_q    <= 1'b0;
      iss_sid_q  <= '0;
      iss_clid_q <= '0;
    end else begin
      fptr_q     <= fptr_d;
      last_q     <= last_d;
      iss_v_q    <= iss_v_d;
      iss_sid_q  <= iss_sid_d;
      iss_clid_q <= iss_clid_d;
    end
  end

  // L2 must never return data that has no outstanding tag.
  rd_without_tag: assert property (@(posedge clk) disable iff (!reset) i_rd_v |-> head_valid);

endmodule

// File: tb/tb_l1_clfill_rsp.sv
// tb_l1_clfill_rsp
// Bench for l1_clfill_rsp: a directed vector table, hand-written corner
// sequences, and randomized traffic, all compared every cycle against a
// queue-based reference model of the request/response protocol.
module tb_l1_clfill_rsp;

  localparam int NS   = 4;
  localparam int NCL  = 16;
  localparam int CLW  = 512;
  localparam int NOUT = 4;
  localparam int SW   = 2;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     i_set_v;
  logic [NS*CW-1:0]  i_set_clid;
  logic [NS-1:0]     i_clreq_v;
  logic [NS-1:0]     i_clreq_r;
  logic              o_rd_v;
  logic              o_rd_r;
  logic [SW-1:0]     o_rd_sid;
  logic [CW-1:0]     o_rd_clid;
  logic              i_rd_v;
  logic              i_rd_r;
  logic [CLW-1:0]    i_rd_data;
  logic              o_wr_v;
  logic [SW-1:0]     o_wr_sid;
  logic [CW-1:0]     o_wr_clid;
  logic [CLW-1:0]    o_wr_data;
  logic [NS-1:0]     o_clrsp_v;
  logic [NS-1:0]     i_clrsp_r;

  l1_clfill_rsp dut (
    .clk        (clk),
    .reset      (reset),
    .i_set_v    (i_set_v),
    .i_set_clid (i_set_clid),
    .i_clreq_v  (i_clreq_v),
    .i_clreq_r  (i_clreq_r),
    .o_rd_v     (o_rd_v),
    .o_rd_r     (o_rd_r),
    .o_rd_sid   (o_rd_sid),
    .o_rd_clid  (o_rd_clid),
    .i_rd_v     (i_rd_v),
    .i_rd_r     (i_rd_r),
    .i_rd_data  (i_rd_data),
    .o_wr_v     (o_wr_v),
    .o_wr_sid   (o_wr_sid),
    .o_wr_clid  (o_wr_clid),
    .o_wr_data  (o_wr_data),
    .o_clrsp_v  (o_clrsp_v),
    .i_clrsp_r  (i_clrsp_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fill pointers, round-robin history, one pending issue
  // slot and an ordered list of outstanding reads.
  int m_fptr [NS];
  int m_last;
  bit m_iss_v;
  int m_iss_sid, m_iss_clid;
  int m_q_sid [$];
  int m_q_clid [$];

  // Outputs captured during the most recent applyStimulus cycle.
  logic [NS-1:0] cap_clreq_r;
  logic          cap_rd_v;
  logic [SW-1:0] cap_rd_sid;
  logic [CW-1:0] cap_rd_clid;
  logic          cap_i_rd_r;
  logic          cap_wr_v;
  logic [SW-1:0] cap_wr_sid;
  logic [CW-1:0] cap_wr_clid;
  logic [NS-1:0] cap_clrsp_v;

  typedef struct {
    logic [NS-1:0]    set_v;
    logic [NS*CW-1:0] set_clid;
    logic [NS-1:0]    clreq_v;
    logic             rd_r;
    logic             rd_v;
    logic [31:0]      data_word;
    logic [NS-1:0]    clrsp_r;
    logic [NS-1:0]    exp_clreq_r;
    logic             exp_rd_v;
    logic [SW-1:0]    exp_rd_sid;
    logic [CW-1:0]    exp_rd_clid;
    logic             exp_i_rd_r;
    logic             exp_wr_v;
    logic [CW-1:0]    exp_wr_clid;
    logic [NS-1:0]    exp_clrsp_v;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [CLW-1:0] rep(input logic [31:0] w);
    return {16{w}};
  endfunction

  function automatic logic [CLW-1:0] rand_data();
    logic [CLW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_fptr[s] = 0;
    m_last    = NS - 1;
    m_iss_v   = 1'b0;
    m_iss_sid = 0;
    m_iss_clid = 0;
    m_q_sid.delete();
    m_q_clid.delete();
  endtask

  task automatic checkOutput(input string name, input logic [CLW-1:0] act, input logic [CLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_clreq_r"}, i_clreq_r, '0);
    checkOutput({tag, "_rd_v"}, o_rd_v, '0);
    checkOutput({tag, "_rd_sid"}, o_rd_sid, '0);
    checkOutput({tag, "_rd_clid"}, o_rd_clid, '0);
    checkOutput({tag, "_i_rd_r"}, i_rd_r, '0);
    checkOutput({tag, "_wr_v"}, o_wr_v, '0);
    checkOutput({tag, "_wr_sid"}, o_wr_sid, '0);
    checkOutput({tag, "_wr_clid"}, o_wr_clid, '0);
    checkOutput({tag, "_wr_data"}, o_wr_data, '0);
    checkOutput({tag, "_clrsp_v"}, o_clrsp_v, '0);
  endtask

  // Entered at a negedge: asserts reset mid-cycle with the current request
  // inputs still applied, checks outputs, then releases at a later negedge.
  task automatic do_reset(input string tag);
    reset  = 1'b0;
    i_rd_v = 1'b0;
    #1;
    check_reset_outputs(tag);
    i_set_v    = '0;
    i_set_clid = '0;
    i_clreq_v  = '0;
    o_rd_r     = 1'b0;
    i_rd_data  = '0;
    i_clrsp_r  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One cycle: drive inputs at the negedge, compare against the model,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input logic [NS-1:0] set_v, input logic [NS*CW-1:0] set_clid,
                               input logic [NS-1:0] clreq_v, input logic rd_r, input logic rd_v,
                               input logic [CLW-1:0] data, input logic [NS-1:0] clrsp_r);
    int            inflight, gs, hs, hc;
    bit            head_v, exp_i_rd_r, fire;
    logic [NS-1:0] exp_grant, exp_rsp;
    i_set_v    = set_v;
    i_set_clid = set_clid;
    i_clreq_v  = clreq_v;
    o_rd_r     = rd_r;
    i_rd_v     = rd_v;
    i_rd_data  = data;
    i_clrsp_r  = clrsp_r;
    #1;
    inflight = (m_iss_v ? 1 : 0) + m_q_sid.size();
    gs = -1;
    if (inflight < NOUT && (!m_iss_v || rd_r)) begin
      for (int k = 1; k <= NS; k++) begin
        if (gs < 0 && clreq_v[(m_last + k) % NS] && !set_v[(m_last + k) % NS]) gs = (m_last + k) % NS;
      end
    end
    exp_grant = '0;
    if (gs >= 0) exp_grant[gs] = 1'b1;
    head_v     = (m_q_sid.size() != 0);
    hs         = head_v ? m_q_sid[0] : 0;
    hc         = head_v ? m_q_clid[0] : 0;
    exp_i_rd_r = head_v && clrsp_r[hs];
    fire       = rd_v && exp_i_rd_r;
    exp_rsp    = '0;
    if (fire) exp_rsp[hs] = 1'b1;

    checkOutput("m_clreq_r", i_clreq_r, exp_grant);
    checkOutput("m_rd_v", o_rd_v, m_iss_v);
    if (m_iss_v) begin
      checkOutput("m_rd_sid", o_rd_sid, m_iss_sid);
      checkOutput("m_rd_clid", o_rd_clid, m_iss_clid);
    end
    checkOutput("m_i_rd_r", i_rd_r, exp_i_rd_r);
    checkOutput("m_wr_v", o_wr_v, fire);
    checkOutput("m_clrsp_v", o_clrsp_v, exp_rsp);
    if (fire) begin
      checkOutput("m_wr_sid", o_wr_sid, hs);
      checkOutput("m_wr_clid", o_wr_clid, hc);
      checkOutput("m_wr_data", o_wr_data, data);
    end

    cap_clreq_r = i_clreq_r;
    cap_rd_v    = o_rd_v;
    cap_rd_sid  = o_rd_sid;
    cap_rd_clid = o_rd_clid;
    cap_i_rd_r  = i_rd_r;
    cap_wr_v    = o_wr_v;
    cap_wr_sid  = o_wr_sid;
    cap_wr_clid = o_wr_clid;
    cap_clrsp_v = o_clrsp_v;

    @(posedge clk);
    if (fire) begin
      void'(m_q_sid.pop_front());
      void'(m_q_clid.pop_front());
    end
    if (m_iss_v && rd_r) begin
      m_q_sid.push_back(m_iss_sid);
      m_q_clid.push_back(m_iss_clid);
      m_iss_v = 1'b0;
    end
    if (gs >= 0) begin
      m_iss_v    = 1'b1;
      m_iss_sid  = gs;
      m_iss_clid = m_fptr[gs];
      m_fptr[gs] = (m_fptr[gs] + 1) % NCL;
      m_last     = gs;
    end
    for (int s = 0; s < NS; s++) begin
      if (set_v[s]) m_fptr[s] = int'(set_clid[s*CW +: CW]);
    end
    @(negedge clk);
  endtask

  initial begin
    int grants;

    // Stream 1 restarted at line 14: three reads wrap 14, 15, 0; the
    // returns exercise hold-while-not-ready and a per-stream response stall.
    vecs[0] = '{4'b0010, 16'h00E0, 4'b0010, 1'b1, 1'b0, 32'h0,      4'hF, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 4'd0,  4'b0000};
    vecs[1] = '{4'b0000, 16'h0000, 4'b0010, 1'b1, 1'b0, 32'h0,      4'hF, 4'b0010, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 4'd0,  4'b0000};
    vecs[2] = '{4'b0000, 16'h0000, 4'b0010, 1'b1, 1'b0, 32'h0,      4'hF, 4'b0010, 1'b1, 2'd1, 4'd14, 1'b0, 1'b0, 4'd0,  4'b0000};
    vecs[3] = '{4'b0000, 16'h0000, 4'b0010, 1'b1, 1'b0, 32'h0,      4'hF, 4'b0010, 1'b1, 2'd1, 4'd15, 1'b1, 1'b0, 4'd0,  4'b0000};
    vecs[4] = '{4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b1, 32'hD1D1D1, 4'hF, 4'b0000, 1'b1, 2'd1, 4'd0,  1'b1, 1'b1, 4'd14, 4'b0010};
    vecs[5] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 32'h0,      4'hF, 4'b0000, 1'b1, 2'd1, 4'd0,  1'b1, 1'b0, 4'd0,  4'b0000};
    vecs[6] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 32'hD2D2D2, 4'hD, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 4'd0,  4'b0000};
    vecs[7] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 32'hD2D2D2, 4'hF, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b1, 1'b1, 4'd15, 4'b0010};
    vecs[8] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 32'hD3D3D3, 4'hF, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b1, 1'b1, 4'd0,  4'b0010};
    vecs[9] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 32'h0,      4'hF, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 4'd0,  4'b0000};

    reset = 1'b0;
    i_set_v = '0; i_set_clid = '0; i_clreq_v = '0; o_rd_r = 1'b0;
    i_rd_v = 1'b0; i_rd_data = '0; i_clrsp_r = '0;
    @(negedge clk);
    do_reset("reset0");

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].set_v, vecs[i].set_clid, vecs[i].clreq_v, vecs[i].rd_r,
                    vecs[i].rd_v, rep(vecs[i].data_word), vecs[i].clrsp_r);
      checkOutput($sformatf("vec%0d_clreq_r", i), cap_clreq_r, vecs[i].exp_clreq_r);
      checkOutput($sformatf("vec%0d_rd_v", i), cap_rd_v, vecs[i].exp_rd_v);
      if (vecs[i].exp_rd_v) begin
        checkOutput($sformatf("vec%0d_rd_sid", i), cap_rd_sid, vecs[i].exp_rd_sid);
        checkOutput($sformatf("vec%0d_rd_clid", i), cap_rd_clid, vecs[i].exp_rd_clid);
      end
      checkOutput($sformatf("vec%0d_i_rd_r", i), cap_i_rd_r, vecs[i].exp_i_rd_r);
      checkOutput($sformatf("vec%0d_wr_v", i), cap_wr_v, vecs[i].exp_wr_v);
      checkOutput($sformatf("vec%0d_clrsp_v", i), cap_clrsp_v, vecs[i].exp_clrsp_v);
      if (vecs[i].exp_wr_v) begin
        checkOutput($sformatf("vec%0d_wr_sid", i), cap_wr_sid, 2'd1);
        checkOutput($sformatf("vec%0d_wr_clid", i), cap_wr_clid, vecs[i].exp_wr_clid);
      end
    end

    $display("[TB] round-robin with continuous return");
    do_reset("reset_rr");
    for (int c = 0; c < 8; c++) begin
      applyStimulus('0, '0, 4'hF, 1'b1, (m_q_sid.size() != 0), rep(32'hA000 + c), 4'hF);
      checkOutput($sformatf("rr_grant%0d", c), cap_clreq_r, 4'b0001 << (c % NS));
    end

    $display("[TB] in-flight limit");
    do_reset("reset_full");
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus('0, '0, 4'hF, 1'b1, 1'b0, '0, 4'hF);
      if (cap_clreq_r != '0) grants++;
    end
    checkOutput("full_grant_count", grants, 4);
    checkOutput("full_blocked", cap_clreq_r, '0);
    applyStimulus('0, '0, 4'hF, 1'b1, 1'b1, rep(32'hF00D), 4'hF);
    checkOutput("full_pop_write", cap_wr_v, 1'b1);
    checkOutput("full_pop_same_cycle", cap_clreq_r, '0);
    applyStimulus('0, '0, 4'hF, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("full_reopen", cap_clreq_r, 4'b0001);
    applyStimulus('0, '0, 4'hF, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("full_again", cap_clreq_r, '0);

    $display("[TB] response stall on stream 2");
    do_reset("reset_stall");
    applyStimulus('0, '0, 4'b0100, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("stall_grant", cap_clreq_r, 4'b0100);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, '0, 4'hF);
    applyStimulus('0, '0, '0, 1'b1, 1'b1, rep(32'hC2C2C2C2), 4'b1011);
    checkOutput("stall_i_rd_r", cap_i_rd_r, 1'b0);
    checkOutput("stall_wr_v", cap_wr_v, 1'b0);
    applyStimulus('0, '0, '0, 1'b1, 1'b1, rep(32'hC2C2C2C2), 4'hF);
    checkOutput("unstall_wr_v", cap_wr_v, 1'b1);
    checkOutput("unstall_wr_sid", cap_wr_sid, 2'd2);
    checkOutput("unstall_clrsp_v", cap_clrsp_v, 4'b0100);

    $display("[TB] set and request in the same cycle");
    do_reset("reset_set");
    applyStimulus(4'b0001, 16'h0005, 4'b0001, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("set_blocks_grant", cap_clreq_r, '0);
    applyStimulus('0, '0, 4'b0001, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("set_then_grant", cap_clreq_r, 4'b0001);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("set_rd_v", cap_rd_v, 1'b1);
    checkOutput("set_rd_clid", cap_rd_clid, 4'd5);

    $display("[TB] reset with reads in flight");
    do_reset("reset_pre");
    for (int c = 0; c < 3; c++) applyStimulus('0, '0, 4'hF, 1'b1, 1'b0, '0, 4'hF);
    i_clreq_v = 4'hF;
    i_clrsp_r = 4'hF;
    o_rd_r    = 1'b1;
    do_reset("reset_mid");
    applyStimulus('0, '0, 4'hF, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("post_reset_grant", cap_clreq_r, 4'b0001);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, '0, 4'hF);
    checkOutput("post_reset_rd_sid", cap_rd_sid, 2'd0);
    checkOutput("post_reset_rd_clid", cap_rd_clid, 4'd0);

    $display("[TB] randomized traffic");
    do_reset("reset_rand");
    for (int c = 0; c < 600; c++) begin
      logic [NS-1:0]    sv;
      logic [NS*CW-1:0] sc;
      logic [NS-1:0]    cr;
      logic [NS-1:0]    rr;
      sv = ($urandom_range(0, 9) == 0) ? NS'($urandom()) : '0;
      sc = (NS*CW)'($urandom());
      cr = NS'($urandom());
      rr = ($urandom_range(0, 3) != 0) ? 4'hF : NS'($urandom());
      applyStimulus(sv, sc, cr, ($urandom_range(0, 3) != 0),
                    (m_q_sid.size() != 0) && ($urandom_range(0, 2) != 0), rand_data(), rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_clfill_rsp.md
# l1_clfill_rsp

Responder side of the L1 cacheline request/response handshake. Accepts per-stream cacheline requests from `nstreams` L1 stream pointers, arbitrates round-robin, and tracks each stream's next fill line id (wrapping modulo `ncl`). It issues tagged in-order reads to L2 storage, writes returned lines into the L1 line buffer, and pulses the per-stream cacheline response that increments the requester's valid-line count.

## Interface
- `nstreams`, 4, number of L1 streams served
- `ncl`, 16, cachelines per stream in L1 (power of two)
- `cl_width`, 512, cacheline data bits
- `nout`, 4, max L2 reads in flight (issue stage plus tag queue)
- `sid_width`, `$clog2(nstreams)`, stream id bits
- `clid_width`, `$clog2(ncl)`, line id bits
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `i_set_v`  in  nstreams  per-stream restart: load fill pointer
- `i_set_clid`  in  nstreams*clid_width  start line id per stream (stream s at `[s*clid_width +: clid_width]`)
- `i_clreq_v`  in  nstreams  per-stream cacheline request
- `i_clreq_r`  out  nstreams  request accepted (grant)
- `o_rd_v`  out  1  L2 read valid
- `o_rd_r`  in  1  L2 read ready
- `o_rd_sid`  out  sid_width  stream of the read
- `o_rd_clid`  out  clid_width  destination line id
- `i_rd_v`  in  1  L2 data valid (in issue order)
- `i_rd_r`  out  1  L2 data ready
- `i_rd_data`  in  cl_width  line data
- `o_wr_v`  out  1  L1 line buffer write enable
- `o_wr_sid`  out  sid_width  write stream
- `o_wr_clid`  out  clid_width  write line id
- `o_wr_data`  out  cl_width  write data
- `o_clrsp_v`  out  nstreams  one-hot response to stream
- `i_clrsp_r`  in  nstreams  per-stream response ready

## Operation
- Per-stream fill pointer `fptr[s]`, reset 0. `i_set_v[s]` loads `i_set_clid[s]`; a grant to s increments `fptr[s]` modulo `ncl` (natural wrap 15→0).
- Eligibility: `i_clreq_v[s] & ~i_set_v[s]`. Set wins: no grant to a stream in the cycle it is set.
- Capacity: `inflight` = issue-stage occupancy + tag-queue count. Grant only if `inflight < nout`, and the issue stage is empty or `o_rd_r` is high.
- Round-robin arbiter: at most one grant per cycle; search starts at `last+1` (mod nstreams), where `last` is the most recent grantee. `last` resets to `nstreams-1`, so stream 0 has first priority.
- Grant loads the issue stage with `{s, fptr[s]}` (pre-increment value).
- On `o_rd_v & o_rd_r`, push tag `{sid, clid}` into the tag queue. Pushing and popping in the same cycle is allowed.
- Response: the head tag selects the stream. `i_rd_r = head_valid & i_clrsp_r[head_sid]`.
- On `i_rd_v & i_rd_r`: `o_wr_v=1` with the head sid/clid and `i_rd_data`; `o_clrsp_v[head_sid]=1`; pop the head.
- `i_rd_v` with an empty tag queue is a protocol error. `i_rd_r` stays low; assertion only.
- A set on a stream with reads outstanding does not cancel them. They complete to their original clid.

## Timing
- Reset values: `i_clreq_r=0`, `o_rd_v=0`, `i_rd_r=0`, `o_wr_v=0`, `o_clrsp_v=0`. Sid, clid and data outputs are 0.
- Request to read: grant in cycle t; `o_rd_v` high at t+1 (registered issue stage).
- Issue stage holds its values stable while `o_rd_v & ~o_rd_r`.
- Response to write: combinational. `o_wr_v` and `o_clrsp_v` assert in the same cycle as the `i_rd` handshake; no extra latency.
- Throughput: one grant and one response per cycle sustained when `nout >= 2` and L2 round trip ≤ `nout-1` cycles.
- Full: when `inflight == nout`, all `i_clreq_r=0`. A pop in the same cycle does not free a slot until the next cycle.
- Empty: `i_rd_r=0`.

## Structure
- Package `l1_clfill_pkg`: tag struct `{sid, clid}`, width localparams, and a `rr_next` function for the round-robin search.
- Sub-module `l1_clfill_tagq`: synchronous FIFO, depth `nout`, width `sid_width+clid_width`, with count output.
- The arbiter, fill pointers and issue stage live in the top module.

## Test plan
- Single stream: set s1 clid=14, issue 3 requests → `o_rd_clid` 14, 15, 0 for sid 1. Each data beat yields `o_wr_clid` in that order and `o_clrsp_v=4'b0010`.
- All 4 streams request continuously, `o_rd_r=1` → grants s0,s1,s2,s3,s0,… with one per cycle.
- `nout=4`, L2 never returns data → exactly 4 grants, then `i_clreq_r=0`. Returning 1 beat re-enables exactly 1 grant the following cycle.
- `i_clrsp_r[2]=0` with the head tag on sid 2 → `i_rd_r=0` and no write. Raising it → write plus `o_clrsp_v=4'b0100` in the same cycle.
- `i_set_v[0]` and `i_clreq_v[0]` in the same cycle with `i_set_clid=5` → no grant to s0; the next grant uses clid 5.
- Assert `reset` low mid-traffic with 3 reads in flight → all outputs 0 immediately. After release, the first grant goes to s0 with clid 0.
